// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin owner of one byte-level SPI engine, sequencing whole transactions per requester.
// Optional SPI_ARB_TIMEOUT_EN aborts a transaction whose owner stalls TIMEOUT cycles between bytes.
module spi_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   rsp_valid,
  output logic [7:0]     rsp_data,
  output logic           eng_start,
  output logic [7:0]     eng_tx,
  input  logic           eng_done,
  input  logic [7:0]     eng_rx,
  output logic [N-1:0]   ss_n,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           timeout_err
);
  localparam int IW = $clog2(N);
  typedef enum logic [2:0] {IDLE, SELECT, LOAD, WAIT, TRAIL} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, gidx_q, sel;
  logic [N-1:0]  grant_q, ss_n_q, rsp_valid_q;
  logic [7:0]    eng_tx_q, rsp_data_q;
  logic          last_q, eng_start_q, timeout_err_q;
  logic          any_req, accept, done_ok, tmo;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  // Counter only runs while the owner is silent in LOAD, so engine stalls never abort
  always_ff @(posedge clk) begin
    if (rst || state_q != LOAD) cnt_q <= '0;
    else if (!req_valid[gidx_q]) cnt_q <= cnt_q + 16'd1;
  end
  assign tmo = state_q == LOAD && !req_valid[gidx_q] && (cnt_q + 16'd1) == 16'(TIMEOUT);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = any_req ? SELECT : IDLE;
      SELECT:  state_d = LOAD;
      LOAD:    state_d = accept ? WAIT : tmo ? TRAIL : LOAD;
      WAIT:    state_d = done_ok ? (last_q ? TRAIL : LOAD) : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    any_req   = |req_valid;
    accept    = state_q == LOAD && req_valid[gidx_q];
    done_ok   = state_q == WAIT && eng_done;
    req_ready = state_q == LOAD ? grant_q : '0;
    busy      = state_q != IDLE;
    sel       = ptr_q;
    // Descending scan so the lowest offset from the pointer wins
    for (int k = N - 1; k >= 0; k--)
      if (req_valid[(int'(ptr_q) + k) % N]) sel = IW'((int'(ptr_q) + k) % N);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      gidx_q        <= '0;
      grant_q       <= '0;
      ss_n_q        <= '1;
      eng_tx_q      <= '0;
      last_q        <= 1'b0;
      eng_start_q   <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      eng_start_q   <= accept;
      rsp_valid_q   <= done_ok ? grant_q : '0;
      timeout_err_q <= tmo;
      if (state_q == IDLE && any_req) begin
        gidx_q  <= sel;
        grant_q <= N'(1) << sel;
        ss_n_q  <= ~(N'(1) << sel);
      end
      if (accept) begin
        eng_tx_q <= req_data[8*gidx_q +: 8];
        last_q   <= req_last[gidx_q];
      end
      if (done_ok) rsp_data_q <= eng_rx;
      if (state_q == TRAIL) begin
        grant_q <= '0;
        ss_n_q  <= '1;
        ptr_q   <= (int'(gidx_q) == N - 1) ? '0 : gidx_q + 1'b1;
      end
    end
  end
  assign grant       = grant_q;
  assign ss_n        = ss_n_q;
  assign eng_tx      = eng_tx_q;
  assign eng_start   = eng_start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: cycle table for reset/handshake/rst-in-WAIT plus sequences with a 16-cycle inverting engine model.
module tb_spi_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tbl = 1'b1;
  logic [3:0]  req_valid, req_last, req_ready, rsp_valid, ss_n, grant;
  logic [31:0] req_data;
  logic [7:0]  rsp_data, eng_tx, eng_rx;
  logic        eng_start, eng_done, busy, timeout_err;
  logic [3:0]  t_v = '0, t_l = '0, m_v = '0, m_l = '0, hold = '0;
  logic [31:0] t_d = '0, m_d = '0;
  logic        t_dn = 1'b0, m_done;
  logic [7:0]  t_rx = '0, m_rx;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign req_valid = tbl ? t_v : m_v;
  assign req_data  = tbl ? t_d : m_d;
  assign req_last  = tbl ? t_l : m_l;
  assign eng_done  = tbl ? t_dn : m_done;
  assign eng_rx    = tbl ? t_rx : m_rx;

  spi_arbiter #(.N(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .eng_start(eng_start),
    .eng_tx(eng_tx), .eng_done(eng_done), .eng_rx(eng_rx), .ss_n(ss_n), .grant(grant),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Engine model: returns the inverted byte 16 cycles after eng_start
  logic       e_busy;
  int         e_cnt;
  logic [7:0] e_byte;
  always @(posedge clk) begin
    if (rst) begin
      e_busy <= 1'b0; m_done <= 1'b0; m_rx <= '0; e_cnt <= 0; e_byte <= '0;
    end else begin
      m_done <= 1'b0;
      if (eng_start) begin
        e_busy <= 1'b1; e_cnt <= 15; e_byte <= ~eng_tx;
      end else if (e_busy) begin
        if (e_cnt == 0) begin
          m_done <= 1'b1; m_rx <= e_byte; e_busy <= 1'b0;
        end else e_cnt <= e_cnt - 1;
      end
    end
  end

  logic [8:0]  rq[4][$];
  logic [15:0] tx_log[$], rsp_log[$], grant_log[$];
  logic [3:0]  prev_ss = 4'hF;
  int          inv_bad = 0, gap_bad = 0, tmo_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] at(input logic [15:0] q[$], input int k);
    return k < q.size() ? q[k] : 16'hxxxx;
  endfunction

  // One cycle: observe outputs at negedge, then drive requesters for the coming edge
  task automatic step();
    @(negedge clk);
    if (eng_start) tx_log.push_back({8'h00, eng_tx});
    if (|rsp_valid) rsp_log.push_back({4'h0, rsp_valid, rsp_data});
    if (timeout_err) tmo_cnt++;
    if (ss_n != ~grant || $countones(~ss_n) > 1) inv_bad++;
    if (ss_n != 4'hF && prev_ss == 4'hF) grant_log.push_back({12'h000, grant});
    if (ss_n != 4'hF && prev_ss != 4'hF && ss_n != prev_ss) gap_bad++;
    prev_ss = ss_n;
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 1'b0; m_l[i] = 1'b0; m_d[8*i +: 8] = 8'h00;
      if (rq[i].size() > 0 && !hold[i]) begin
        m_v[i] = 1'b1; m_l[i] = rq[i][0][8]; m_d[8*i +: 8] = rq[i][0][7:0];
        if (req_ready[i]) void'(rq[i].pop_front());
      end
    end
  endtask

  task automatic run_until_idle(input string nm, input int bound);
    int n = 0;
    do begin step(); n++; end
    while ((busy || rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() > 0) && n < bound);
    chk(nm, n < bound, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; hold = '0; m_v = '0; m_l = '0; m_d = '0;
    for (int i = 0; i < 4; i++) rq[i].delete();
    @(negedge clk);
    rst = 1'b0;
    tx_log.delete(); rsp_log.delete(); grant_log.delete();
    prev_ss = 4'hF;
  endtask

  typedef struct packed {
    logic r; logic [3:0] v; logic [31:0] d; logic [3:0] l; logic dn; logic [7:0] rx;
    logic [3:0] ss, g; logic b; logic [3:0] rdy; logic st; logic [3:0] rv; logic [7:0] rd, tx;
  } vec_t;
  vec_t tv[17];

  initial begin
    int n;
    //           r  v     d              l     dn rx      ss    g     b  rdy   st rv    rd     tx
    tv[0]  = '{1'b1, 4'h0, 32'h0,        4'h0, 1'b0, 8'h00, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 8'h00};
    tv[1]  = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b0, 8'h00, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 8'h00};
    tv[2]  = '{1'b0, 4'h1, 32'h11,       4'h1, 1'b0, 8'h00, 4'hE, 4'h1, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 8'h00};
    tv[3]  = '{1'b0, 4'h1, 32'h11,       4'h1, 1'b0, 8'h00, 4'hE, 4'h1, 1'b1, 4'h1, 1'b0, 4'h0, 8'h00, 8'h00};
    tv[4]  = '{1'b0, 4'h1, 32'h11,       4'h1, 1'b0, 8'h00, 4'hE, 4'h1, 1'b1, 4'h0, 1'b1, 4'h0, 8'h00, 8'h11};
    tv[5]  = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b0, 8'h00, 4'hE, 4'h1, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 8'h11};
    tv[6]  = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 8'h77, 4'hE, 4'h1, 1'b1, 4'h0, 1'b0, 4'h1, 8'h77, 8'h11};
    tv[7]  = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b0, 8'h00, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h77, 8'h11};
    tv[8]  = '{1'b0, 4'h1, 32'h22,       4'h1, 1'b0, 8'h00, 4'hE, 4'h1, 1'b1, 4'h0, 1'b0, 4'h0, 8'h77, 8'h11};
    tv[9]  = '{1'b0, 4'h5, 32'h00AA0022, 4'h5, 1'b0, 8'h00, 4'hE, 4'h1, 1'b1, 4'h1, 1'b0, 4'h0, 8'h77, 8'h11};
    tv[10] = '{1'b0, 4'h5, 32'h00AA0022, 4'h5, 1'b0, 8'h00, 4'hE, 4'h1, 1'b1, 4'h0, 1'b1, 4'h0, 8'h77, 8'h22};
    tv[11] = '{1'b1, 4'h0, 32'h0,        4'h0, 1'b1, 8'h99, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 8'h00};
    tv[12] = '{1'b0, 4'h1, 32'h33,       4'h1, 1'b0, 8'h00, 4'hE, 4'h1, 1'b1, 4'h0, 1'b0, 4'h0, 8'h00, 8'h00};
    tv[13] = '{1'b0, 4'h1, 32'h33,       4'h1, 1'b1, 8'hEE, 4'hE, 4'h1, 1'b1, 4'h1, 1'b0, 4'h0, 8'h00, 8'h00};
    tv[14] = '{1'b0, 4'h1, 32'h33,       4'h1, 1'b0, 8'h00, 4'hE, 4'h1, 1'b1, 4'h0, 1'b1, 4'h0, 8'h00, 8'h33};
    tv[15] = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b1, 8'h44, 4'hE, 4'h1, 1'b1, 4'h0, 1'b0, 4'h1, 8'h44, 8'h33};
    tv[16] = '{1'b0, 4'h0, 32'h0,        4'h0, 1'b0, 8'h00, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h44, 8'h33};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst = tv[i].r; t_v = tv[i].v; t_d = tv[i].d; t_l = tv[i].l; t_dn = tv[i].dn; t_rx = tv[i].rx;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          {ss_n, grant, busy, req_ready, eng_start, rsp_valid, rsp_data, eng_tx, timeout_err},
          {tv[i].ss, tv[i].g, tv[i].b, tv[i].rdy, tv[i].st, tv[i].rv, tv[i].rd, tv[i].tx, 1'b0});
    end
    @(negedge clk);
    t_v = '0; t_dn = 1'b0; tbl = 1'b0;

    do_reset();
    repeat (10) step();
    chk("idle_outputs", {ss_n, grant, busy}, {4'hF, 4'h0, 1'b0});
    chk("idle_no_start", tx_log.size(), 0);

    // Requester 2, three bytes
    rq[2].push_back({1'b0, 8'hA5}); rq[2].push_back({1'b0, 8'h3C}); rq[2].push_back({1'b1, 8'h81});
    run_until_idle("A_done", 400);
    chk("A_tx0", at(tx_log, 0), 16'h00A5);
    chk("A_tx1", at(tx_log, 1), 16'h003C);
    chk("A_tx2", at(tx_log, 2), 16'h0081);
    chk("A_rsp0", at(rsp_log, 0), 16'h045A);
    chk("A_rsp1", at(rsp_log, 1), 16'h04C3);
    chk("A_rsp2", at(rsp_log, 2), 16'h047E);
    chk("A_one_select", grant_log.size(), 1);
    chk("A_grant", at(grant_log, 0), 16'h0004);

    // Requesters 0,1,3 competing, two single-byte transactions each
    do_reset();
    rq[0].push_back({1'b1, 8'h10}); rq[0].push_back({1'b1, 8'h40});
    rq[1].push_back({1'b1, 8'h21}); rq[1].push_back({1'b1, 8'h51});
    rq[3].push_back({1'b1, 8'h33}); rq[3].push_back({1'b1, 8'h63});
    run_until_idle("B_done", 1000);
    chk("B_g0", at(grant_log, 0), 16'h0001);
    chk("B_g1", at(grant_log, 1), 16'h0002);
    chk("B_g2", at(grant_log, 2), 16'h0008);
    chk("B_g3", at(grant_log, 3), 16'h0001);
    chk("B_g4", at(grant_log, 4), 16'h0002);
    chk("B_g5", at(grant_log, 5), 16'h0008);
    chk("B_tx_order", {at(tx_log, 0)[7:0], at(tx_log, 1)[7:0], at(tx_log, 2)[7:0],
                       at(tx_log, 3)[7:0], at(tx_log, 4)[7:0], at(tx_log, 5)[7:0]}, 48'h102133405163);
    chk("B_rsp3", at(rsp_log, 3), 16'h01BF);
    chk("B_gap", gap_bad, 0);

    // Requester 1 stalls 5 cycles between bytes
    do_reset();
    rq[1].push_back({1'b0, 8'h0F}); rq[1].push_back({1'b0, 8'hF0}); rq[1].push_back({1'b1, 8'h5A});
    n = 0;
    while (tx_log.size() < 1 && n < 100) begin step(); n++; end
    chk("C_first_start", n < 100, 1'b1);
    hold[1] = 1'b1;
    n = 0;
    while (rsp_log.size() < 1 && n < 100) begin step(); n++; end
    chk("C_first_rsp", n < 100, 1'b1);
    n = 0;
    for (int i = 0; i < 5; i++) begin step(); if (ss_n !== 4'hD) n++; end
    chk("C_hold_ss", n, 0);
    chk("C_hold_no_start", tx_log.size(), 1);
    hold[1] = 1'b0;
    run_until_idle("C_done", 400);
    chk("C_tx", {at(tx_log, 0)[7:0], at(tx_log, 1)[7:0], at(tx_log, 2)[7:0]}, 24'h0FF05A);
    chk("C_rsp", {at(rsp_log, 0), at(rsp_log, 1), at(rsp_log, 2)}, 48'h02F0_020F_02A5);
    chk("C_one_select", grant_log.size(), 1);

`ifdef SPI_ARB_TIMEOUT_EN
    // Requester 0 stalls after its first byte until the abort
    do_reset();
    rq[0].push_back({1'b0, 8'h12}); rq[0].push_back({1'b1, 8'h34});
    n = 0;
    while (tx_log.size() < 1 && n < 100) begin step(); n++; end
    hold[0] = 1'b1;
    n = 0;
    while (rsp_log.size() < 1 && n < 100) begin step(); n++; end
    n = 0;
    while (!timeout_err && n < 30) begin step(); n++; end
    chk("D_tmo_delay", n, 8);
    chk("D_tmo_ss", ss_n, 4'hE);
    step();
    chk("D_release", {ss_n, timeout_err, busy}, {4'hF, 1'b0, 1'b0});
    rq[0].delete(); hold[0] = 1'b0; grant_log.delete();
    rq[0].push_back({1'b1, 8'h55}); rq[1].push_back({1'b1, 8'h66});
    run_until_idle("D_done", 400);
    chk("D_ptr_adv", at(grant_log, 0), 16'h0002);
    chk("D_tmo_once", tmo_cnt, 1);
`else
    chk("no_timeout", tmo_cnt, 0);
`endif
    chk("ss_grant_invariant", inv_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
